ber_meas_ctrl: RTL

//  Measurement-window controller in front of the BER 7-segment display block.
//  - Counts received bits and bit errors over a fixed gate window of clock cycles.
//  - Snapshots both counts onto RECV_CNT/ERR_CNT and pulses START so the display

---
 rtl/ber_meas_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ber_meas_ctrl.sv
// BER measurement-window controller: counts received bits and bit errors
// over a fixed gate window, snapshots the counts, pulses START for the
// display block, holds for a settle period, then rearms (RUN) or stops (SINGLE).
module ber_meas_ctrl #(
  parameter int BW_WIN   = 32,
  parameter int WIN_LEN  = 100_000_000,
  parameter int BW_HOLD  = 16,
  parameter int HOLD_LEN = 4096
) (
  input  logic        CLK,
  input  logic        RSTX,
  input  logic        RUN,
  input  logic        SINGLE,
  input  logic        BIT_VALID,
  input  logic        BIT_ERR,
  output logic [57:0] RECV_CNT,
  output logic [63:0] ERR_CNT,
  output logic        START,
  output logic        NODATA,
  output logic        MEASURING,
  output logic        DONE
);

  typedef enum logic [2:0] {IDLE, CLEAR, GATE, SNAP, HOLD} state_t;

  localparam logic [BW_WIN-1:0]  WIN_LAST  = BW_WIN'(WIN_LEN - 1);
  localparam logic [BW_HOLD-1:0] HOLD_LAST = BW_HOLD'(HOLD_LEN - 1);

  state_t              state, state_nxt;
  logic                single_mode, single_nxt;
  logic [BW_WIN-1:0]   win_cnt;
  logic [BW_HOLD-1:0]  hold_cnt, hold_nxt;
  logic [57:0]         acc_recv, acc_recv_nxt;
  logic [63:0]         acc_err;
  logic                recv_inc, err_inc;

  // Saturating accumulate; an error is only counted while it keeps err <= recv,
  // so the ratio stays meaningful even once the bit count has saturated.
  always_comb begin
    recv_inc     = BIT_VALID && (acc_recv != '1);
    acc_recv_nxt = acc_recv + 58'(recv_inc);
    err_inc      = BIT_VALID && BIT_ERR && (acc_err != '1) &&
                   ({6'b0, acc_recv_nxt} > acc_err);
  end

  // Next-state logic; a latched single shot ignores RUN until it finishes.
  always_comb begin
    state_nxt  = state;
    single_nxt = single_mode;
    hold_nxt   = (state == HOLD) ? hold_cnt + BW_HOLD'(1) : '0;
    case (state)
      IDLE: begin
        if (RUN) begin
          state_nxt  = CLEAR;
          single_nxt = 1'b0;
        end else if (SINGLE) begin
          state_nxt  = CLEAR;
          single_nxt = 1'b1;
        end
      end
      CLEAR: state_nxt = GATE;
      GATE: begin
        if (!single_mode && !RUN) state_nxt = IDLE;
        else if (win_cnt == WIN_LAST) state_nxt = SNAP;
      end
      SNAP: state_nxt = HOLD;
      HOLD: begin
        if (hold_cnt == HOLD_LAST)
          state_nxt = (RUN && !single_mode) ? CLEAR : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, mode and hold counter registers.
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state       <= IDLE;
      single_mode <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      single_mode <= single_nxt;
      hold_cnt    <= hold_nxt;
    end
  end

  // Window counter and accumulators: cleared in CLEAR, advanced in GATE.
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      win_cnt  <= '0;
      acc_recv <= '0;
      acc_err  <= '0;
    end else if (state == CLEAR) begin
      win_cnt  <= '0;
      acc_recv <= '0;
      acc_err  <= '0;
    end else if (state == GATE) begin
      win_cnt  <= win_cnt + BW_WIN'(1);
      acc_recv <= acc_recv_nxt;
      acc_err  <= acc_err + 64'(err_inc);
    end
  end

  // Registered outputs; START is withheld when the divisor would be zero.
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      RECV_CNT  <= '0;
      ERR_CNT   <= '0;
      START     <= 1'b0;
      NODATA    <= 1'b0;
      MEASURING <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      START     <= 1'b0;
      MEASURING <= (state_nxt == GATE);
      DONE      <= (state_nxt == HOLD) && (hold_nxt == HOLD_LAST);
      if (state == SNAP) begin
        RECV_CNT <= acc_recv;
        ERR_CNT  <= acc_err;
        NODATA   <= (acc_recv == '0);
        START    <= (acc_recv != '0);
      end
    end
  end

endmodule
